mult_seq_ctrl: RTL and testbench

MULT_SEQ_CTRL -- requirements
Module: mult_seq_ctrl

---
 rtl/mult_pkg.sv | 12 +
 rtl/add_ripple.sv | 27 ++
 rtl/mult_seq_ctrl.sv | 96 +++++++++
 tb/tb_mult_seq_ctrl.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// Shared types and defaults for the sequential shift-add multiplier.
package mult_pkg;

    localparam int WIDTH_DEF = 4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/add_ripple.sv
// WIDTH-bit ripple-carry adder built from one full-adder cell per bit.
module add_ripple
    import mult_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    logic [WIDTH:0] w_carry;

    assign w_carry[0] = cin;

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_fa
            assign sum[gi]         = a[gi] ^ b[gi] ^ w_carry[gi];
            assign w_carry[gi + 1] = (a[gi] & b[gi]) | (w_carry[gi] & (a[gi] ^ b[gi]));
        end
    endgenerate

    assign cout = w_carry[WIDTH];

endmodule

// File: rtl/mult_seq_ctrl.sv
// Sequential unsigned multiplier: one shift-add step per clock, fixed WIDTH-cycle
// latency, valid/ready handshakes on both operand input and product output.
module mult_seq_ctrl
    import mult_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   z,
    output logic                 busy
);

    localparam int                CNT_W    = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(WIDTH - 1);

    state_t                r_state;
    state_t                w_state_next;
    logic [2*WIDTH-1:0]    r_acc;
    logic [WIDTH-1:0]      r_mcand;
    logic [CNT_W-1:0]      r_cnt;

    logic [WIDTH-1:0]      w_addend;
    logic [WIDTH-1:0]      w_sum;
    logic                  w_cout;
    logic [2*WIDTH-1:0]    w_acc_step;

    // Multiplicand is added to the upper half only when the current multiplier LSB is set.
    assign w_addend = r_acc[0] ? r_mcand : '0;

    add_ripple #(
        .WIDTH (WIDTH)
    ) u_add (
        .a    (r_acc[2*WIDTH-1:WIDTH]),
        .b    (w_addend),
        .cin  (1'b0),
        .sum  (w_sum),
        .cout (w_cout)
    );

    assign w_acc_step = {w_cout, w_sum, r_acc[WIDTH-1:1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (in_valid) w_state_next = S_CALC;
            S_CALC:  if (r_cnt == CNT_LAST) w_state_next = S_DONE;
            S_DONE:  if (out_ready) w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc   <= '0;
            r_mcand <= '0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_mcand <= a;
                        r_acc   <= {{WIDTH{1'b0}}, b};
                        r_cnt   <= '0;
                    end
                end
                S_CALC: begin
                    r_acc <= w_acc_step;
                    r_cnt <= r_cnt + CNT_W'(1);
                end
                default: ;
            endcase
        end
    end

    // All outputs decode from registered state only.
    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = (r_state == S_DONE);
    assign busy      = (r_state != S_IDLE);
    assign z         = r_acc;

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// Self-checking bench for mult_seq_ctrl (WIDTH=4): vector table, reset abort, exhaustive sweep.
module tb_mult_seq_ctrl;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] a;
    logic [3:0] b;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] z;
    logic       busy;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] exp_q[$];

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic [7:0] exp_z;
        int         hold;
        bit         inject;
    } vec_t;

    vec_t vecs[6];

    mult_seq_ctrl #(
        .WIDTH (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .z         (z),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pop_expected(output logic [7:0] e);
        if (exp_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL scoreboard_empty: got output with no expected entry, expected one queued");
            e = 8'hxx;
        end else begin
            e = exp_q.pop_front();
        end
    endtask

    task automatic run_op(input logic [3:0] ta, input logic [3:0] tb_b,
                          input logic [7:0] exp_z, input int hold, input bit inject);
        int         guard;
        int         cyc;
        logic [7:0] e;
        guard = 0;
        while (!in_ready && guard < 50) begin
            tick();
            guard++;
        end
        check("op_in_ready_wait", int'(in_ready), 1);
        in_valid = 1'b1;
        a        = ta;
        b        = tb_b;
        exp_q.push_back(exp_z);
        tick();
        in_valid = 1'b0;
        cyc = 0;
        while (!out_valid && cyc < 20) begin
            if (inject && cyc == 1) begin
                in_valid = 1'b1;
                a        = 4'd3;
                b        = 4'd3;
            end
            tick();
            cyc++;
        end
        in_valid = 1'b0;
        check("op_latency", cyc, 4);
        pop_expected(e);
        for (int h = 0; h < hold; h++) begin
            check("hold_out_valid", int'(out_valid), 1);
            check("hold_z", int'(z), int'(e));
            check("hold_in_ready", int'(in_ready), 0);
            tick();
        end
        out_ready = 1'b1;
        check("op_out_valid", int'(out_valid), 1);
        check("op_z", int'(z), int'(e));
        $display("op %0d*%0d -> z=%0d latency=%0d hold=%0d inject=%0d", ta, tb_b, z, cyc, hold, inject);
        tick();
        out_ready = 1'b0;
        check("post_out_valid", int'(out_valid), 0);
        check("post_in_ready", int'(in_ready), 1);
    endtask

    initial begin
        vecs[0] = '{a: 4'd9,  b: 4'd6,  exp_z: 8'd54,  hold: 0, inject: 1'b0};
        vecs[1] = '{a: 4'd15, b: 4'd15, exp_z: 8'd225, hold: 0, inject: 1'b0};
        vecs[2] = '{a: 4'd0,  b: 4'd13, exp_z: 8'd0,   hold: 0, inject: 1'b0};
        vecs[3] = '{a: 4'd7,  b: 4'd0,  exp_z: 8'd0,   hold: 0, inject: 1'b0};
        vecs[4] = '{a: 4'd9,  b: 4'd6,  exp_z: 8'd54,  hold: 5, inject: 1'b0};
        vecs[5] = '{a: 4'd9,  b: 4'd6,  exp_z: 8'd54,  hold: 0, inject: 1'b1};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        repeat (2) tick();
        check("reset_in_ready", int'(in_ready), 1);
        check("reset_out_valid", int'(out_valid), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_z", int'(z), 0);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 6; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].exp_z, vecs[i].hold, vecs[i].inject);
        end

        // Reset asserted on the second CALC cycle abandons the operation.
        in_valid = 1'b1;
        a        = 4'd9;
        b        = 4'd6;
        tick();
        in_valid = 1'b0;
        tick();
        check("abort_busy_before", int'(busy), 1);
        rst_n = 1'b0;
        #1;
        check("abort_in_ready", int'(in_ready), 1);
        check("abort_out_valid", int'(out_valid), 0);
        check("abort_busy", int'(busy), 0);
        check("abort_z", int'(z), 0);
        $display("abort: reset mid-CALC, z=%0d in_ready=%0d", z, in_ready);
        @(negedge clk);
        rst_n = 1'b1;
        run_op(4'd5, 4'd5, 8'd25, 0, 1'b0);

        // Exhaustive back-to-back sweep with random backpressure.
        fork
            begin : driver
                for (int ia = 0; ia < 16; ia++) begin
                    for (int ib = 0; ib < 16; ib++) begin
                        bit acc;
                        int guard;
                        in_valid = 1'b1;
                        a        = 4'(ia);
                        b        = 4'(ib);
                        guard    = 0;
                        acc      = 1'b0;
                        while (!acc && guard < 100) begin
                            acc = in_ready;
                            if (acc) exp_q.push_back(8'(ia * ib));
                            tick();
                            guard++;
                        end
                        if (!acc) check("sweep_accept_timeout", 0, 1);
                    end
                end
                in_valid = 1'b0;
            end
            begin : monitor
                int         got;
                int         cyc;
                logic [7:0] e;
                got = 0;
                cyc = 0;
                while (got < 256 && cyc < 256 * 40) begin
                    out_ready = 1'($urandom_range(0, 1));
                    if (out_valid && out_ready) begin
                        pop_expected(e);
                        check("sweep_z", int'(z), int'(e));
                        $display("sweep #%0d z=%0d expected=%0d", got, z, e);
                        got++;
                    end
                    tick();
                    cyc++;
                end
                out_ready = 1'b0;
                check("sweep_count", got, 256);
            end
        join
        check("sweep_queue_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
